mux_rr_feeder: RTL

Round-robin arbitration stage wrapped around the 4-bit 4-to-1 mux (`mux_Nbit_4to1`). It takes four request lines, drives the mux select with the winning index and captures the mux output into a one-entry output register. The output register is drained through a valid/ready handshake. Upstream of this block are four independent producers; downstream is any consumer that speaks valid/ready.

---
 rtl/mux_rr_feeder_if.sv | 25 ++
 rtl/mux_rr_feeder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/mux_rr_feeder_if.sv
// mux_rr_feeder_if: request/ack, mux select/feedback and output handshake bundle
// for the round-robin mux feeder. The master side is the arbiter itself.
interface mux_rr_feeder_if #(
    parameter int W = 4
);
    logic [3:0]   req;
    logic [3:0]   ack;
    logic [1:0]   sel;
    logic [W-1:0] mux_o;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         o_ready;
    logic [1:0]   o_src;
    logic [31:0]  grant_cnt;

    modport master (
        input  req, mux_o, o_ready,
        output ack, sel, o_data, o_valid, o_src, grant_cnt
    );

    modport slave (
        output req, mux_o, o_ready,
        input  ack, sel, o_data, o_valid, o_src, grant_cnt
    );
endinterface

// File: rtl/mux_rr_feeder.sv
// mux_rr_feeder: round-robin arbiter driving an external 4-to-1 mux select and
// capturing the mux output into a one-entry valid/ready output register.
// Optional per-producer saturating grant counters: define MUX_RR_FEEDER_STATS_EN.
module mux_rr_feeder #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    mux_rr_feeder_if.master bus
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   last_sel_q, last_sel_d;
    logic [1:0]   src_q, src_d;
    logic [W-1:0] data_q, data_d;

    logic [1:0]   winner;
    logic         any_req;
    logic         can_take;
    logic         take;

    // Winner: first requester scanning from ptr upward, modulo 4
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req  = |bus.req;
    assign can_take = (state_q == EMPTY) || bus.o_ready;
    assign take     = can_take && any_req;

    // Combinational ack/sel; both forced low while reset is asserted
    always_comb begin
        bus.ack = '0;
        bus.sel = '0;
        if (!rst) begin
            if (take)
                bus.ack[winner] = 1'b1;
            bus.sel = any_req ? winner : last_sel_q;
        end
    end

    // Next-state: capture on take, otherwise drain or hold
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        last_sel_d = last_sel_q;
        src_d      = src_q;
        data_d     = data_q;
        if (take) begin
            state_d    = FULL;
            data_d     = bus.mux_o;
            src_d      = winner;
            ptr_d      = winner + 2'd1;
            last_sel_d = winner;
        end else if (state_q == FULL && bus.o_ready) begin
            state_d = EMPTY;
        end
    end

    // Output register, priority pointer and last select
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            ptr_q      <= '0;
            last_sel_q <= '0;
            src_q      <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            last_sel_q <= last_sel_d;
            src_q      <= src_d;
            data_q     <= data_d;
        end
    end

    assign bus.o_valid = (state_q == FULL);
    assign bus.o_data  = data_q;
    assign bus.o_src   = src_q;

`ifdef MUX_RR_FEEDER_STATS_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    // Per-producer grant counters, saturating at 255
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (take && winner == 2'(i) && cnt_q[i] != 8'hFF)
                cnt_d[i] = cnt_q[i] + 8'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 4; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.grant_cnt = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
    assign bus.grant_cnt = '0;
`endif
endmodule
